// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter granting four requesters single-cycle write access to a shared register.
// Each access walks IDLE -> GRANT -> COMMIT; the write lands on the edge that leaves COMMIT.
module reg_access_arbiter #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [NREQ-1:0]         i_req,
   input  logic [2*NREQ-1:0]       i_op,
   input  logic [NREQ*WIDTH-1:0]   i_data,
   output logic [NREQ-1:0]         o_gnt,
   output logic [NREQ-1:0]         o_ack,
   output logic [WIDTH-1:0]        o_q,
   output logic                    o_busy,
   output logic [7:0]              o_wr_cnt
);

   // state    | meaning
   // S_IDLE   | no transaction; arbitrate any pending request
   // S_GRANT  | winner granted; abort if its request has dropped
   // S_COMMIT | winner's op applied to the register on exit, ack pulsed
   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_COMMIT} state_t;

   localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [1:0]        win_q, win_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic [WIDTH-1:0]  q_q, q_d;
   logic [7:0]        wr_cnt_q, wr_cnt_d;

   logic [1:0]        rr_win;
   logic              rr_found;
   logic [1:0]        rr_idx;
   logic [1:0]        win_op;
   logic [WIDTH-1:0]  win_data;

   // First requester at or after the pointer, wrapping around
   always_comb begin
      rr_win   = 2'd0;
      rr_found = 1'b0;
      rr_idx   = 2'd0;
      for (int i = 0; i < NREQ; i++) begin
         rr_idx = ptr_q + i[1:0];
         if (!rr_found && i_req[rr_idx]) begin
            rr_win   = rr_idx;
            rr_found = 1'b1;
         end
      end
   end

   assign win_op   = i_op[{win_q, 1'b0} +: 2];
   assign win_data = i_data[win_q*WIDTH +: WIDTH];

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      win_d    = win_q;
      gnt_d    = gnt_q;
      ack_d    = '0;
      q_d      = q_q;
      wr_cnt_d = wr_cnt_q;
      case (state_q)
         S_IDLE: begin
            gnt_d = '0;
            if (rr_found) begin
               win_d   = rr_win;
               gnt_d   = ONE_HOT0 << rr_win;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            if (i_req[win_q]) begin
               state_d = S_COMMIT;
            end else begin
               gnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         S_COMMIT: begin
            case (win_op)
               2'b00:   q_d = win_data;
               2'b01:   q_d = '1;
               2'b10:   q_d = '0;
               default: q_d = q_q;
            endcase
            ack_d    = ONE_HOT0 << win_q;
            wr_cnt_d = wr_cnt_q + 8'd1;
            ptr_d    = win_q + 2'd1;
            gnt_d    = '0;
            state_d  = S_IDLE;
         end
         default: begin
            gnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         ptr_q    <= 2'd0;
         win_q    <= 2'd0;
         gnt_q    <= '0;
         ack_q    <= '0;
         q_q      <= '0;
         wr_cnt_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         win_q    <= win_d;
         gnt_q    <= gnt_d;
         ack_q    <= ack_d;
         q_q      <= q_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   assign o_gnt    = gnt_q;
   assign o_ack    = ack_q;
   assign o_q      = q_q;
   assign o_busy   = (state_q != S_IDLE);
   assign o_wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Randomised and directed bench for reg_access_arbiter against a transaction-level model.
module tb_reg_access_arbiter;

   localparam int WIDTH = 8;

   logic           i_clk = 1'b0;
   logic           i_rst = 1'b1;
   logic [3:0]     i_req = '0;
   logic [7:0]     i_op = '0;
   logic [31:0]    i_data = '0;
   logic [3:0]     o_gnt;
   logic [3:0]     o_ack;
   logic [7:0]     o_q;
   logic           o_busy;
   logic [7:0]     o_wr_cnt;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   reg_access_arbiter #(.WIDTH(WIDTH), .NREQ(4)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_op(i_op), .i_data(i_data),
      .o_gnt(o_gnt), .o_ack(o_ack), .o_q(o_q), .o_busy(o_busy), .o_wr_cnt(o_wr_cnt)
   );

   always #5 i_clk = ~i_clk;

   // Model: a transaction is "cycles into the access" (0 idle, 1 granted, 2 committing)
   int   m_phase = 0;
   int   m_win = 0;
   int   m_ptr = 0;
   int   m_q = 0;
   int   m_cnt = 0;
   int   m_ack = 0;
   int   cyc = 0;
   int   log_win[$];
   int   log_cyc[$];

   always @(posedge i_clk) begin
      cyc++;
      if (i_rst) begin
         m_phase = 0; m_win = 0; m_ptr = 0; m_q = 0; m_cnt = 0; m_ack = 0;
      end else begin
         m_ack = 0;
         if (m_phase == 0) begin
            if (i_req != 0) begin
               for (int k = 0; k < 4; k++) begin
                  if (i_req[(m_ptr + k) % 4]) begin
                     m_win = (m_ptr + k) % 4;
                     break;
                  end
               end
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            m_phase = i_req[m_win] ? 2 : 0;
         end else begin
            case (i_op[2*m_win +: 2])
               2'b00: m_q = int'(i_data[m_win*8 +: 8]);
               2'b01: m_q = 255;
               2'b10: m_q = 0;
               default: ;
            endcase
            m_ack = 1 << m_win;
            m_cnt = (m_cnt + 1) % 256;
            m_ptr = (m_win + 1) % 4;
            m_phase = 0;
            log_win.push_back(m_win);
            log_cyc.push_back(cyc);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge i_clk) begin
      if (cmp_en) begin
         chk("cyc_gnt",  int'(o_gnt),    (m_phase != 0) ? (1 << m_win) : 0);
         chk("cyc_ack",  int'(o_ack),    m_ack);
         chk("cyc_q",    int'(o_q),      m_q);
         chk("cyc_busy", int'(o_busy),   (m_phase != 0) ? 1 : 0);
         chk("cyc_cnt",  int'(o_wr_cnt), m_cnt);
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge i_clk);
   endtask

   task automatic set_req(input int n, input logic [1:0] op, input logic [7:0] d);
      i_req[n] = 1'b1;
      i_op[2*n +: 2] = op;
      i_data[n*8 +: 8] = d;
   endtask

   task automatic do_reset();
      i_rst = 1'b1; i_req = '0;
      tick(2);
      i_rst = 1'b0;
   endtask

   task automatic wait_ack(input string name);
      bit got = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
         @(negedge i_clk);
         if (o_ack != 0) got = 1'b1;
      end
      chk({name, "_ack_seen"}, int'(got), 1);
   endtask

   int base, q_before, cnt_before;

   initial begin
      tick(1);
      cmp_en = 1'b1;
      do_reset();
      chk("rst_gnt", int'(o_gnt), 0);
      chk("rst_q", int'(o_q), 0);
      chk("rst_cnt", int'(o_wr_cnt), 0);
      chk("rst_busy", int'(o_busy), 0);

      // Single load from requester 2
      set_req(2, 2'b00, 8'hA5);
      tick(1);
      chk("ld_gnt", int'(o_gnt), 4'b0100);
      tick(2);
      chk("ld_q", int'(o_q), 8'hA5);
      chk("ld_ack", int'(o_ack), 4'b0100);
      chk("ld_cnt", int'(o_wr_cnt), 1);
      i_req = '0;
      tick(2);

      // Everyone requesting: strict rotation, 3-cycle commit spacing
      do_reset();
      base = log_win.size();
      for (int n = 0; n < 4; n++) set_req(n, 2'b00, 8'(8'h10 + n));
      for (int i = 0; i < 60 && log_win.size() < base + 8; i++) tick(1);
      i_req = '0;
      chk("rr_commits", log_win.size() - base, 8);
      if (log_win.size() >= base + 8) begin
         for (int k = 0; k < 8; k++) chk("rr_order", log_win[base + k], k % 4);
         for (int k = 1; k < 8; k++) chk("rr_space", log_cyc[base + k] - log_cyc[base + k - 1], 3);
      end
      chk("rr_cnt", int'(o_wr_cnt), 8);
      chk("rr_q", int'(o_q), 8'h13);
      tick(2);

      // Set, clear, no-op
      set_req(1, 2'b01, 8'h00); wait_ack("set"); i_req = '0;
      chk("set_q", int'(o_q), 8'hFF);
      tick(2);
      set_req(3, 2'b10, 8'h77); wait_ack("clr"); i_req = '0;
      chk("clr_q", int'(o_q), 8'h00);
      tick(2);
      cnt_before = int'(o_wr_cnt);
      set_req(0, 2'b11, 8'h5A); wait_ack("nop"); i_req = '0;
      chk("nop_q", int'(o_q), 8'h00);
      chk("nop_cnt", int'(o_wr_cnt), cnt_before + 1);
      tick(2);

      // Abort in GRANT leaves everything, including the pointer
      do_reset();
      set_req(0, 2'b00, 8'h99);
      tick(1);
      chk("ab_gnt", int'(o_gnt), 4'b0001);
      i_req = '0;
      tick(1);
      chk("ab_busy", int'(o_busy), 0);
      chk("ab_gnt0", int'(o_gnt), 0);
      chk("ab_q", int'(o_q), 0);
      chk("ab_cnt", int'(o_wr_cnt), 0);
      set_req(0, 2'b00, 8'h21);
      set_req(1, 2'b00, 8'h42);
      tick(1);
      chk("ab_ptr_gnt", int'(o_gnt), 4'b0001);
      i_req = '0;
      tick(3);

      // Reset during COMMIT kills the write
      do_reset();
      set_req(2, 2'b00, 8'h3C);
      tick(2);
      chk("rc_busy", int'(o_busy), 1);
      i_rst = 1'b1;
      tick(1);
      i_rst = 1'b0; i_req = '0;
      chk("rc_q", int'(o_q), 0);
      chk("rc_ack", int'(o_ack), 0);
      chk("rc_cnt", int'(o_wr_cnt), 0);
      chk("rc_busy0", int'(o_busy), 0);
      tick(1);

      // 256 commits wrap the counter
      do_reset();
      set_req(0, 2'b11, 8'h00);
      for (int k = 0; k < 255; k++) wait_ack("wrap");
      chk("wrap_255", int'(o_wr_cnt), 255);
      wait_ack("wrap");
      i_req = '0;
      chk("wrap_0", int'(o_wr_cnt), 0);
      tick(2);

      // Random traffic, including rogue requesters and occasional resets
      for (int i = 0; i < 3000; i++) begin
         i_rst  = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 3) == 0) i_req = 4'($urandom);
         if ($urandom_range(0, 3) == 0) i_op = 8'($urandom);
         if ($urandom_range(0, 3) == 0) i_data = 32'($urandom);
         tick(1);
      end
      i_rst = 1'b0; i_req = '0;
      tick(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
